note_phase_counter: RTL and testbench
=====================================

# note_phase_counter

Upstream oscillator stage for the sequential divider. It keeps a per-note phase counter that advances once per sample tick and wraps at the note period. At each tick it presents `count` (the phase), `divider` (the period) and a one-cycle `flag`. The divider turns these into the 8-bit normalized phase `count*256/divider`, which forms the sawtooth sample.

## Interface
- `SAMPLE_DIV`, default 256: clock cycles per sample tick (12 MHz / 256 = 46.875 kHz). Legal range is 16..65535, which guarantees the divider finishes before the next `flag`.
- `clk` in 1: system clock. This block has one clock only.
- `rst` in 1: reset, synchronous and active-high.
- `note_valid` in 1: single-cycle request to select a new note.
- `note_idx` in 4: semitone 0..11 (C..B). Values 12..15 are illegal.
- `octave` in 3: octave shift 0..6. Value 7 is illegal.
- `gate` in 1: when 1, the oscillator runs. When 0, the phase is held at 0.
- `count` out 16: phase value, always `< divider`.
- `divider` out 16: current note period, in sample ticks.
- `flag` out 1: one-cycle pulse marking a new `count`/`divider` pair.
- `wrap` out 1: asserted together with `flag` when `count` returned to 0 by wrap or by a note change.

## Operation
- Base periods at octave 0 (C1..B1) are 1433, 1353, 1277, 1205, 1138, 1074, 1014, 957, 903, 852, 804, 759.
- Period formula: `period = BASE[note_idx] >> octave`. The minimum is 759>>6 = 11.
- Note request handling:
  - A `note_valid` with a legal `note_idx` and `octave` registers `pending_period` on the next edge.
  - A request with an illegal field is ignored entirely; `pending_period` is unchanged.
  - If several requests arrive between ticks, the last one wins.
- The tick prescaler `tick_cnt` counts 0..SAMPLE_DIV-1 and wraps. A tick is the cycle in which `tick_cnt == SAMPLE_DIV-1`.
- On the edge that ends a tick cycle:
  - `flag` is set to 1 for exactly one cycle.
  - If `gate == 0`: `count` = 0, `divider` = `pending_period`, `wrap` = 1.
  - Else, if `pending_period != divider`: `count` = 0, `divider` = `pending_period`, `wrap` = 1.
  - Otherwise: `count` = `count+1`, or 0 if `count+1 == divider`. `wrap` = 1 only in the 0 case.
- Outside tick updates, `count` and `divider` hold their values. `wrap` and `flag` are 0.
- Invariant: `count < divider` at all times, so the divider quotient fits in 8 bits.

## Timing
- Reset values:
  - `tick_cnt` = 0, `pending_period` = 1433, `count` = 0, `divider` = 1433.
  - `flag` = 0, `wrap` = 0.
- Asserting `rst` mid-operation restores these values on the next edge and drops any pending note.
- The first `flag` after `rst` deasserts is high during the cycle following the SAMPLE_DIV-th rising edge. After that, `flag` repeats every SAMPLE_DIV cycles exactly.
- `count`, `divider`, `flag` and `wrap` are all registered and change on the same edge. `count` and `divider` then stay stable for SAMPLE_DIV cycles.
- Note latency is one cycle into `pending_period`, so the update lands on the first tick edge after that.
- A `note_valid` sampled in a tick cycle misses that tick and takes effect at the following tick.
- `gate` is sampled only at tick edges.

## Structure
- Package `synth_pkg` holds:
  - the `NOTE_PERIOD[12]` 16-bit constant table;
  - the `SAMPLE_DIV_DEFAULT` constant;
  - the `PHASE_W = 16` width constant;
  - the `note_t` typedef (4-bit index plus 3-bit octave).
- Sub-module `sample_tick_gen` (parameter `SAMPLE_DIV`, ports `clk`, `rst`, `tick`) contains the prescaler.
- The top level contains the note latch, period lookup and phase register.

## Test plan
- Reset and first tick: hold `rst` for 3 cycles with SAMPLE_DIV=16. Outputs must read 0/1433/0/0, and the first `flag` must rise 16 cycles after release. Subsequent flags must be spaced exactly 16 apart.
- Wrap: set `gate`=1 and note A (idx 9) at octave 6, giving `divider` 13. `count` must step 0,1,…,12,0 on successive flags, with `wrap` high only alongside `count` 0.
- Mid-cycle note change: while `count` = 5 with C at octave 6 (period 22), request E at octave 6. At the next tick, `count` must be 0, `divider` 17 and `wrap` 1.
- Illegal requests: issue `note_idx` = 12, then `octave` = 7. `divider` must be unchanged and `wrap` must not assert at the next tick.
- Coincident request: pulse `note_valid` in the cycle where `tick_cnt == 15`. `divider` must be unchanged at that tick and updated at the next tick.
- Gate and reset: drop `gate`, which forces `count` = 0 with `wrap` = 1 at every tick. Then assert `rst` while `count` = 7, which must restore all reset values on the next edge.

Source files
------------

// File: rtl/note_phase_counter_pkg.sv
// Shared constants and types for the note phase oscillator.
package synth_pkg;

  localparam int unsigned PHASE_W            = 16;
  localparam int unsigned SAMPLE_DIV_DEFAULT = 256;

  // Octave-0 periods (C1..B1) in sample ticks
  localparam logic [PHASE_W-1:0] NOTE_PERIOD [12] = '{
    16'd1433, 16'd1353, 16'd1277, 16'd1205, 16'd1138, 16'd1074,
    16'd1014, 16'd957,  16'd903,  16'd852,  16'd804,  16'd759
  };

  typedef struct packed {
    logic [3:0] idx;
    logic [2:0] oct;
  } note_t;

  function automatic logic note_legal(input note_t n);
    return (n.idx <= 4'd11) && (n.oct != 3'd7);
  endfunction

  function automatic logic [PHASE_W-1:0] note_period(input note_t n);
    if (n.idx > 4'd11) return '0;
    return NOTE_PERIOD[n.idx] >> n.oct;
  endfunction

endpackage

// File: rtl/note_phase_counter_if.sv
// Note request / phase output bundle between the oscillator and its neighbours.
interface note_phase_counter_if;
  import synth_pkg::*;

  logic               note_valid;
  logic [3:0]         note_idx;
  logic [2:0]         octave;
  logic               gate;
  logic [PHASE_W-1:0] count;
  logic [PHASE_W-1:0] divider;
  logic               flag;
  logic               wrap;

  modport master (
    output note_valid, note_idx, octave, gate,
    input  count, divider, flag, wrap
  );

  modport slave (
    input  note_valid, note_idx, octave, gate,
    output count, divider, flag, wrap
  );
endinterface

// File: rtl/note_phase_counter_sample_tick_gen.sv
// Sample-rate prescaler: tick is high for one cycle out of every SAMPLE_DIV.
module sample_tick_gen
  import synth_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = SAMPLE_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned     CNT_W = $clog2(SAMPLE_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_DIV - 1);

  logic [CNT_W-1:0] r_tick_cnt;

  always_ff @(posedge clk) begin
    if (rst)                     r_tick_cnt <= '0;
    else if (r_tick_cnt == LAST) r_tick_cnt <= '0;
    else                         r_tick_cnt <= r_tick_cnt + CNT_W'(1);
  end

  assign tick = (r_tick_cnt == LAST);

endmodule

// File: rtl/note_phase_counter.sv
// Per-note phase counter: latches note requests, advances phase once per sample tick.
module note_phase_counter
  import synth_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = SAMPLE_DIV_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  note_phase_counter_if.slave  bus
);

  logic               w_tick;
  note_t              w_note;
  logic               w_req_ok;
  logic [PHASE_W-1:0] w_req_period;
  logic [PHASE_W-1:0] w_count_inc;

  logic [PHASE_W-1:0] r_pending;
  logic [PHASE_W-1:0] r_count;
  logic [PHASE_W-1:0] r_divider;
  logic               r_flag;
  logic               r_wrap;

  sample_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  always_comb begin
    w_note       = {bus.note_idx, bus.octave};
    w_req_ok     = bus.note_valid && note_legal(w_note);
    w_req_period = note_period(w_note);
    w_count_inc  = r_count + PHASE_W'(1);
  end

  // The tick update reads the old pending value, so a request in the tick cycle lands a tick later
  always_ff @(posedge clk) begin
    if (rst)           r_pending <= NOTE_PERIOD[0];
    else if (w_req_ok) r_pending <= w_req_period;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= '0;
      r_divider <= NOTE_PERIOD[0];
      r_flag    <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_flag <= w_tick;
      r_wrap <= 1'b0;
      if (w_tick) begin
        if (!bus.gate || (r_pending != r_divider)) begin
          r_count   <= '0;
          r_divider <= r_pending;
          r_wrap    <= 1'b1;
        end else if (w_count_inc == r_divider) begin
          r_count <= '0;
          r_wrap  <= 1'b1;
        end else begin
          r_count <= w_count_inc;
        end
      end
    end
  end

  assign bus.count   = r_count;
  assign bus.divider = r_divider;
  assign bus.flag    = r_flag;
  assign bus.wrap    = r_wrap;

endmodule

// File: tb/tb_note_phase_counter.sv
// Scoreboard bench for note_phase_counter with SAMPLE_DIV = 16.
module tb_note_phase_counter;
  import synth_pkg::*;

  localparam int unsigned SDIV = 16;

  typedef struct {
    logic [15:0] count;
    logic [15:0] divider;
    logic        wrap;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  note_phase_counter_if bus();

  note_phase_counter #(.SAMPLE_DIV(SDIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rst_req  = 0;
  int   rst_done = 0;
  logic done     = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: owns every counter, checks flag spacing and pops the scoreboard
  int unsigned cyc = 0;
  int unsigned ref_cyc = 0;
  exp_t e;
  always @(negedge clk) begin
    cyc++;
    if (rst_req != rst_done) begin
      check("reset_count",   bus.count,   16'd0);
      check("reset_divider", bus.divider, 16'd1433);
      check("reset_flag",    16'(bus.flag), 16'd0);
      check("reset_wrap",    16'(bus.wrap), 16'd0);
      rst_done++;
    end
    if (rst) begin
      ref_cyc = cyc + 1;
    end else if (bus.flag) begin
      check("flag_spacing", 16'(cyc - ref_cyc), 16'(SDIV));
      ref_cyc = cyc;
      if (q.size() == 0) begin
        check("unexpected_flag", 16'd1, 16'd0);
      end else begin
        e = q.pop_front();
        check({e.name, "_count"},   bus.count,      e.count);
        check({e.name, "_divider"}, bus.divider,    e.divider);
        check({e.name, "_wrap"},    16'(bus.wrap),  16'(e.wrap));
      end
    end else begin
      check("wrap_without_flag", 16'(bus.wrap), 16'd0);
      if (cyc - ref_cyc > SDIV) begin
        check("missing_flag", 16'(cyc - ref_cyc), 16'(SDIV));
        ref_cyc = cyc;
      end
    end
    if (done) begin
      check("scoreboard_empty", 16'(q.size()), 16'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

  task automatic push(input int c, input int d, input logic w, input string name);
    exp_t x;
    x.count = 16'(c); x.divider = 16'(d); x.wrap = w; x.name = name;
    q.push_back(x);
  endtask

  task automatic pulse_note(input logic [3:0] idx, input logic [2:0] oct);
    bus.note_idx   = idx;
    bus.octave     = oct;
    bus.note_valid = 1'b1;
    @(posedge clk); #1;
    bus.note_valid = 1'b0;
  endtask

  // Returns #1 after the edge that raised flag; bounded so a dead DUT still ends
  task automatic wait_ticks(input int n);
    for (int t = 0; t < n; t++) begin
      for (int i = 0; i < 3 * SDIV; i++) begin
        @(posedge clk); #1;
        if (bus.flag) break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.note_valid = 1'b0;
    bus.note_idx   = 4'd0;
    bus.octave     = 3'd0;
    bus.gate       = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    rst_req++;

    // A at octave 6 = 852>>6 = 13; gate low forces the first tick to count 0
    pulse_note(4'd9, 3'd6);
    push(0, 13, 1'b1, "gate_low_first");
    wait_ticks(1);
    bus.gate = 1'b1;
    for (int i = 1; i <= 12; i++) push(i, 13, 1'b0, "wrap_step");
    push(0, 13, 1'b1, "wrap_zero");
    wait_ticks(13);

    // C at octave 6 = 22, run up to count 5, then E at octave 6 = 17
    pulse_note(4'd0, 3'd6);
    push(0, 22, 1'b1, "note_c");
    for (int i = 1; i <= 5; i++) push(i, 22, 1'b0, "c_step");
    wait_ticks(6);
    repeat (3) @(posedge clk); #1;
    pulse_note(4'd4, 3'd6);
    push(0, 17, 1'b1, "mid_change");
    wait_ticks(1);

    pulse_note(4'd12, 3'd0);
    pulse_note(4'd0, 3'd7);
    push(1, 17, 1'b0, "illegal_ignored");
    wait_ticks(1);

    // Request in the tick cycle (prescaler at 15): held this tick, applied next
    repeat (SDIV - 1) @(posedge clk); #1;
    pulse_note(4'd0, 3'd6);
    push(2, 17, 1'b0, "coincident_hold");
    push(0, 22, 1'b1, "coincident_apply");
    wait_ticks(1);

    bus.gate = 1'b0;
    for (int i = 0; i < 3; i++) push(0, 22, 1'b1, "gate_low");
    wait_ticks(3);
    bus.gate = 1'b1;
    for (int i = 1; i <= 7; i++) push(i, 22, 1'b0, "regate_step");
    wait_ticks(7);

    // Reset while count = 7: outputs restore and the pending note is dropped
    repeat (4) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rst_req++;
    push(1, 1433, 1'b0, "pending_dropped");
    wait_ticks(1);
    repeat (4) @(posedge clk); #1;
    done = 1'b1;
  end

endmodule
